// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with debug halt/single-step FSM.
// Optional stall watchdog enabled by defining PIPE_CTRL_WDOG_EN.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        halt_req,
    input  logic        step_req,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        halted,
    output logic        wdog_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

    state_t      state;
    logic        halted_q;
    logic [5:0]  normal_stall;
    logic        any_stallreq;
    logic        exc_pending;

    assign any_stallreq = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
    assign exc_pending  = (excepttype_i != 32'h0);
    assign state_dbg    = state;

    // Deeper stalls must also hold every earlier stage, hence the thermometer codes.
    always_comb begin
        normal_stall = 6'b000000;
        if (stallreq_mem) begin
            normal_stall = 6'b011111;
        end else if (stallreq_ex) begin
            normal_stall = 6'b001111;
        end else if (stallreq_id) begin
            normal_stall = 6'b000111;
        end else if (stallreq_if) begin
            normal_stall = 6'b000111;
        end
    end

    // Zero-latency outputs; HALTED freezes everything and ignores exceptions.
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (!rst) begin
            if (state == ST_HALTED) begin
                stall = 6'b111111;
            end else if (exc_pending) begin
                flush  = 1'b1;
                new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end else begin
                stall = normal_stall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state <= ST_DRAIN;
                    end
                    halted_q <= 1'b0;
                end
                ST_DRAIN: begin
                    if (!halt_req) begin
                        state    <= ST_RUN;
                        halted_q <= 1'b0;
                    end else if (!any_stallreq && !exc_pending) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        halted_q <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (!halt_req) begin
                        state    <= ST_RUN;
                        halted_q <= 1'b0;
                    end else if (step_req) begin
                        state    <= ST_STEP;
                        halted_q <= 1'b0;
                    end else begin
                        halted_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    // One clean advance, or an exception flush, ends the step.
                    if (exc_pending || !any_stallreq) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign halted = halted_q & ~rst;

`ifdef PIPE_CTRL_WDOG_EN
    logic [7:0] wdog_cnt;
    logic       wdog_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= 8'd0;
            wdog_q   <= 1'b0;
        end else if (state != ST_HALTED && stall[0]) begin
            if (wdog_cnt != 8'd255) begin
                wdog_cnt <= wdog_cnt + 8'd1;
            end
            if (wdog_cnt >= 8'd254) begin
                wdog_q <= 1'b1;
            end
        end else begin
            wdog_cnt <= 8'd0;
        end
    end

    assign wdog_err = wdog_q & ~rst;
`else
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: priority, exceptions, drain/halt,
// single step, reset mid-step and the optional watchdog.
module tb_pipe_ctrl;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

`ifdef PIPE_CTRL_WDOG_EN
    localparam logic WDOG_EN = 1'b1;
`else
    localparam logic WDOG_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        halt_req;
    logic        step_req;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        halted;
    logic        wdog_err;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .halt_req     (halt_req),
        .step_req     (step_req),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .halted       (halted),
        .wdog_err     (wdog_err),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and checks happen 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; halt_req = 1'b1; stallreq_mem = 1'b1; excepttype_i = 32'h1;
        settle();
        n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL rst_stall: got %b want %b", stall, 6'b000000); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_checks++; if (new_pc !== 32'h0) begin n_fail++; $display("FAIL rst_new_pc: got %h want 0", new_pc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
        n_checks++; if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL rst_wdog: got %b want 0", wdog_err); end
        tick();
        n_checks++; if (state_dbg !== S_RUN) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state_dbg, S_RUN); end
        halt_req = 1'b0; stallreq_mem = 1'b0; excepttype_i = 32'h0;
        tick();
        rst = 1'b0;
        settle();
        n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL post_rst_stall: got %b want %b", stall, 6'b000000); end
    endtask

    task automatic test_priority();
        stallreq_if = 1'b1; settle();
        n_checks++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL prio_if: got %b want %b", stall, 6'b000111); end
        stallreq_if = 1'b0; stallreq_id = 1'b1; settle();
        n_checks++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL prio_id: got %b want %b", stall, 6'b000111); end
        stallreq_ex = 1'b1; settle();
        n_checks++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL prio_id_ex: got %b want %b", stall, 6'b001111); end
        stallreq_mem = 1'b1; settle();
        n_checks++; if (stall !== 6'b011111) begin n_fail++; $display("FAIL prio_mem: got %b want %b", stall, 6'b011111); end
        n_checks++; if (flush !== 1'b0 || new_pc !== 32'h0) begin n_fail++; $display("FAIL prio_noflush: got flush=%b pc=%h want 0/0", flush, new_pc); end
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0; settle();
        n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL prio_none: got %b want %b", stall, 6'b000000); end
    endtask

    task automatic test_exception();
        excepttype_i = 32'h1; stallreq_mem = 1'b1; settle();
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL exc_flush: got %b want 1", flush); end
        n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL exc_stall: got %b want %b", stall, 6'b000000); end
        n_checks++; if (new_pc !== 32'h00000020) begin n_fail++; $display("FAIL exc_vector: got %h want %h", new_pc, 32'h00000020); end
        stallreq_mem = 1'b0; excepttype_i = 32'he; cp0_epc_i = 32'hBFC00100; settle();
        n_checks++; if (new_pc !== 32'hBFC00100) begin n_fail++; $display("FAIL eret_pc: got %h want %h", new_pc, 32'hBFC00100); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL eret_flush: got %b want 1", flush); end
        excepttype_i = 32'h0; settle();
        n_checks++; if (flush !== 1'b0 || new_pc !== 32'h0) begin n_fail++; $display("FAIL exc_clear: got flush=%b pc=%h want 0/0", flush, new_pc); end
    endtask

    task automatic test_drain_halt();
        halt_req = 1'b1; stallreq_ex = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (state_dbg !== S_DRAIN) begin n_fail++; $display("FAIL drain_state%0d: got %0d want %0d", i, state_dbg, S_DRAIN); end
            n_checks++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL drain_stall%0d: got %b want %b", i, stall, 6'b001111); end
            n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_halted%0d: got %b want 0", i, halted); end
            tick();
        end
        stallreq_ex = 1'b0; settle();
        n_checks++; if (state_dbg !== S_DRAIN) begin n_fail++; $display("FAIL drain_last: got %0d want %0d", state_dbg, S_DRAIN); end
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %b want 1", halted); end
        n_checks++; if (stall !== 6'b111111) begin n_fail++; $display("FAIL halt_stall: got %b want %b", stall, 6'b111111); end
        excepttype_i = 32'h1; settle();
        n_checks++; if (flush !== 1'b0 || stall !== 6'b111111 || new_pc !== 32'h0) begin n_fail++; $display("FAIL halt_exc_ignored: got flush=%b stall=%b pc=%h want 0/111111/0", flush, stall, new_pc); end
        tick();
        n_checks++; if (state_dbg !== S_HALTED) begin n_fail++; $display("FAIL halt_stay: got %0d want %0d", state_dbg, S_HALTED); end
        excepttype_i = 32'h0;
    endtask

    task automatic test_single_step();
        step_req = 1'b1; tick(); step_req = 1'b0; settle();
        n_checks++; if (state_dbg !== S_STEP) begin n_fail++; $display("FAIL step_state: got %0d want %0d", state_dbg, S_STEP); end
        n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL step_advance: got %b want %b", stall, 6'b000000); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL step_halted: got %b want 0", halted); end
        tick();
        n_checks++; if (halted !== 1'b1 || stall !== 6'b111111) begin n_fail++; $display("FAIL step_rehalt: got halted=%b stall=%b want 1/111111", halted, stall); end
        // Step blocked by a stall request stays in STEP until the pipe moves.
        step_req = 1'b1; tick(); step_req = 1'b0; stallreq_id = 1'b1; settle();
        n_checks++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL step_blocked: got %b want %b", stall, 6'b000111); end
        tick();
        n_checks++; if (state_dbg !== S_STEP) begin n_fail++; $display("FAIL step_hold: got %0d want %0d", state_dbg, S_STEP); end
        stallreq_id = 1'b0; tick();
        n_checks++; if (state_dbg !== S_HALTED) begin n_fail++; $display("FAIL step_done: got %0d want %0d", state_dbg, S_HALTED); end
        // Exception during step flushes and returns to HALTED.
        step_req = 1'b1; tick(); step_req = 1'b0; stallreq_mem = 1'b1; excepttype_i = 32'h4; settle();
        n_checks++; if (flush !== 1'b1 || stall !== 6'b000000 || new_pc !== 32'h20) begin n_fail++; $display("FAIL step_exc: got flush=%b stall=%b pc=%h want 1/000000/20", flush, stall, new_pc); end
        tick();
        stallreq_mem = 1'b0; excepttype_i = 32'h0;
        n_checks++; if (state_dbg !== S_HALTED) begin n_fail++; $display("FAIL step_exc_halt: got %0d want %0d", state_dbg, S_HALTED); end
        halt_req = 1'b0; tick();
        n_checks++; if (state_dbg !== S_RUN || stall !== 6'b000000 || halted !== 1'b0) begin n_fail++; $display("FAIL resume_run: got st=%0d stall=%b halted=%b want 0/000000/0", state_dbg, stall, halted); end
    endtask

    task automatic test_reset_mid_step();
        halt_req = 1'b1; tick(); tick();
        n_checks++; if (state_dbg !== S_HALTED) begin n_fail++; $display("FAIL rms_halted: got %0d want %0d", state_dbg, S_HALTED); end
        step_req = 1'b1; tick(); step_req = 1'b0; stallreq_id = 1'b1; settle();
        n_checks++; if (state_dbg !== S_STEP || stall !== 6'b000111) begin n_fail++; $display("FAIL rms_step: got st=%0d stall=%b want 3/000111", state_dbg, stall); end
        rst = 1'b1; settle();
        n_checks++; if (stall !== 6'b000000 || halted !== 1'b0) begin n_fail++; $display("FAIL rms_same_cycle: got stall=%b halted=%b want 000000/0", stall, halted); end
        tick();
        n_checks++; if (state_dbg !== S_RUN) begin n_fail++; $display("FAIL rms_state: got %0d want %0d", state_dbg, S_RUN); end
        rst = 1'b0; halt_req = 1'b0; stallreq_id = 1'b0; tick();
        n_checks++; if (state_dbg !== S_RUN || halted !== 1'b0) begin n_fail++; $display("FAIL rms_after: got st=%0d halted=%b want 0/0", state_dbg, halted); end
    endtask

    task automatic test_wdog();
        stallreq_ex = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        n_checks++; if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL wdog_254: got %b want 0", wdog_err); end
        tick();
        n_checks++; if (wdog_err !== WDOG_EN) begin n_fail++; $display("FAIL wdog_255: got %b want %b", wdog_err, WDOG_EN); end
        stallreq_ex = 1'b0; tick(); tick();
        n_checks++; if (wdog_err !== WDOG_EN) begin n_fail++; $display("FAIL wdog_sticky: got %b want %b", wdog_err, WDOG_EN); end
        rst = 1'b1; tick(); rst = 1'b0; settle();
        n_checks++; if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL wdog_clear: got %b want 0", wdog_err); end
    endtask

    initial begin
        rst = 1'b1; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
        stallreq_mem = 1'b0; excepttype_i = 32'h0; cp0_epc_i = 32'h0;
        halt_req = 1'b0; step_req = 1'b0;
        test_reset();
        test_priority();
        test_exception();
        test_drain_halt();
        test_single_step();
        test_reset_mid_step();
        test_wdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have ports stallreq_if, stallreq_id, stallreq_ex and stallreq_mem, each input, 1 bit: per-stage stall requests.
REQ-004 The block SHALL have port excepttype_i, input, 32 bits: exception code from MEM; nonzero means take an exception.
REQ-005 The block SHALL have port cp0_epc_i, input, 32 bits: EPC value used as the ERET target.
REQ-006 The block SHALL have port halt_req, input, 1 bit: debug halt request, level.
REQ-007 The block SHALL have port step_req, input, 1 bit: debug single-step request, level.
REQ-008 The block SHALL have port stall, output, 6 bits: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold.
REQ-009 The block SHALL have port flush, output, 1 bit: clear all pipeline registers and redirect PC.
REQ-010 The block SHALL have port new_pc, output, 32 bits: redirect target, valid when flush=1.
REQ-011 The block SHALL have port halted, output, 1 bit: 1 while in state HALTED.
REQ-012 The block SHALL have port wdog_err, output, 1 bit: sticky stall-watchdog error.

Function
REQ-013 The FSM SHALL have states RUN, DRAIN, HALTED and STEP, held in a register.
REQ-014 stall, flush and new_pc SHALL be combinational from the current state and the current inputs (zero-latency, so pipeline registers act on the next edge).
REQ-015 The normal stall vector SHALL be resolved by priority, highest first:
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000111
  - none -> 6'b000000
REQ-016 excepttype_i!=0 SHALL override everything in every state except HALTED:
  - flush=1 and stall=6'b000000
  - new_pc=cp0_epc_i if excepttype_i==32'h0000000e (ERET), else new_pc=32'h00000020
REQ-017 When flush=0, new_pc SHALL be 32'h00000000.
REQ-018 In RUN, stall SHALL equal the normal vector; halt_req=1 SHALL transition to DRAIN.
REQ-019 In DRAIN, stall SHALL equal the normal vector, with these transitions:
  - halt_req=0 -> RUN (highest priority)
  - else no stallreq_* and excepttype_i==0 -> HALTED
  - else stay in DRAIN
REQ-020 In HALTED, stall SHALL be 6'b111111, flush=0 and halted=1; excepttype_i SHALL be ignored.
REQ-021 HALTED transitions SHALL be:
  - halt_req=0 -> RUN
  - else step_req=1 -> STEP
  - else stay in HALTED
REQ-022 In STEP, stall SHALL equal the normal vector, with these transitions:
  - the first cycle with no stallreq_* (exactly one instruction advance) -> HALTED
  - an exception flushes and -> HALTED
  - any other cycle stays in STEP
REQ-023 A step_req held high SHALL produce one advance per HALTED->STEP->HALTED round trip; no edge detection is required.

Reset
REQ-024 With rst=1 at a clock edge, state SHALL become RUN.
REQ-025 While rst=1, all outputs SHALL be forced to reset values:
  - stall=6'b000000, flush=0, new_pc=32'h0
  - halted=0, wdog_err=0
REQ-026 Reset asserted in any state, including mid-DRAIN or mid-STEP, SHALL abort the halt/step sequence with no residual state.

Configuration
REQ-027 Macro PIPE_CTRL_WDOG_EN, when defined, SHALL add an 8-bit stall counter with this behaviour:
  - increments each cycle with stall[0]=1 in state RUN, DRAIN or STEP
  - clears on any cycle with stall[0]=0 or in HALTED
  - saturates at 255
  - on reaching 255, sets wdog_err=1, which stays set until rst
REQ-028 With PIPE_CTRL_WDOG_EN undefined, no counter SHALL exist and wdog_err SHALL be constant 0.

Verification
REQ-029 The bench SHALL cover priority: stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111; add stallreq_mem=1 -> 6'b011111.
REQ-030 The bench SHALL cover exceptions:
  - excepttype_i=32'h1 with stallreq_mem=1 -> flush=1, stall=0, new_pc=32'h00000020
  - excepttype_i=32'he, cp0_epc_i=32'hBFC00100 -> new_pc=32'hBFC00100
REQ-031 The bench SHALL cover drain-then-halt: halt_req=1 with stallreq_ex held for 3 cycles -> DRAIN for 3 cycles with stall=6'b001111, then halted=1 and stall=6'b111111.
REQ-032 The bench SHALL cover single step: in HALTED, step_req=1 for 1 cycle -> next cycle stall=0 (one advance), following cycle halted=1; halt_req=0 -> RUN, stall=0.
REQ-033 The bench SHALL cover reset mid-STEP: rst=1 during STEP with stallreq_id=1 -> same-cycle stall=0, state RUN after the edge, halted=0.
REQ-034 The bench SHALL cover the watchdog with PIPE_CTRL_WDOG_EN defined: stallreq_ex held 255 cycles -> wdog_err=1, still 1 after the request drops; undefined -> wdog_err=0 throughout.
